// File: rtl/multi_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t       : controller state encoding (IDLE, RUN, DONE)
//   WIDTH_DEFAULT : default operand width
//   clog2()       : counter width helper, never returns less than 1
package multi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/param_add_module.sv
// WIDTH-bit ripple-carry adder.
//   a, b : addends
//   sum  : low WIDTH bits of a + b
//   cout : carry out of the top bit
module param_add_module #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // The carry is a block-local variable so the ripple chain stays inside
    // one process rather than forming a feedback vector between bits.
    always_comb begin
        logic carry;
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/param_multi_module.sv
// Sequential shift-add multiplier with optional two's-complement mode.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : request, accepted in IDLE or DONE
//   is_signed, a, b : operands, sampled on the accept edge
//   busy            : high for the WIDTH iteration cycles
//   done            : one-cycle pulse when product has just been updated
//   product         : full 2*WIDTH-bit result, held until next completion
//
// state | meaning
// IDLE  | waiting for a request
// RUN   | one shift-add iteration per cycle
// DONE  | single-cycle completion, may accept a new request
module param_multi_module
    import multi_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               finish;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic               neg;
    logic               mode_signed;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    // The most negative operand negates to itself, which read as unsigned
    // is exactly its magnitude, so no extra bit is needed.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic sgn);
        return (sgn && x[WIDTH-1]) ? ({WIDTH{1'b0}} - x) : x;
    endfunction

    assign mode_signed = is_signed & SIGNED_EN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                    finish     = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign add_b = acc[0] ? mcand : {WIDTH{1'b0}};

    param_add_module #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (acc[2*WIDTH-1:WIDTH]),
        .b    (add_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // {carry, sum, low half} shifted right by one.
    assign acc_next = {add_cout, add_sum, acc[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            cnt     <= '0;
            mcand   <= '0;
            acc     <= '0;
            neg     <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            if (accept) begin
                mcand <= magnitude(a, mode_signed);
                acc   <= {{WIDTH{1'b0}}, magnitude(b, mode_signed)};
                cnt   <= '0;
                neg   <= mode_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            end else if (state == RUN) begin
                acc <= acc_next;
                cnt <= cnt + CNT_W'(1);
                if (finish) begin
                    product <= neg ? ({(2*WIDTH){1'b0}} - acc_next) : acc_next;
                end
            end
        end
    end

endmodule
